// File: rtl/param_lifo_stack.sv
// param_lifo_stack
//   Parametrised LIFO stack used beside datapath blocks as a call/operand stack.
//   One command is executed per enabled clock edge, with this priority:
//   Clear > Replace (Push&Pop) > Push > Pop > Top.
//
// Ports
//   Clk          clock; every state update happens on its rising edge
//   ResetN       synchronous active-low reset; it wins over every command
//   Enable       0: all state and outputs hold, and commands are ignored
//   Push/Pop/Top/Clear/ErrClr  command strobes
//   DataIn       data to push (or replace the top entry with)
//   DataOut      registered read data
//   OutValid     read strobe (see below)
//   Count        number of entries held, 0..DEPTH
//   Full/Empty/AlmostFull/AlmostEmpty  occupancy flags, registered with Count
//   Overflow/Underflow  sticky error flags, cleared by ErrClr
//
// Read handshake: there is no backpressure. OutValid is high for exactly one
// enabled cycle after the edge that sampled a successful Pop, Top or Replace,
// and DataOut carries that data. OutValid drops to 0 on the next enabled cycle
// that has no successful read. While Enable=0, OutValid and DataOut hold.
module param_lifo_stack #(
    parameter int WIDTH     = 8,
    parameter int ADDR_BITS = 4,
    parameter int AF_MARGIN = 2,
    parameter int AE_MARGIN = 2
) (
    input  logic                 Clk,
    input  logic                 ResetN,
    input  logic                 Enable,
    input  logic                 Push,
    input  logic                 Pop,
    input  logic                 Top,
    input  logic                 Clear,
    input  logic                 ErrClr,
    input  logic [WIDTH-1:0]     DataIn,
    output logic [WIDTH-1:0]     DataOut,
    output logic                 OutValid,
    output logic [ADDR_BITS:0]   Count,
    output logic                 Full,
    output logic                 Empty,
    output logic                 AlmostFull,
    output logic                 AlmostEmpty,
    output logic                 Overflow,
    output logic                 Underflow
);

    localparam int                 DEPTH   = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS:0] DEPTH_C = (ADDR_BITS+1)'(DEPTH);
    localparam logic [ADDR_BITS:0] AF_LVL  = (ADDR_BITS+1)'(DEPTH - AF_MARGIN);
    localparam logic [ADDR_BITS:0] AE_LVL  = (ADDR_BITS+1)'(AE_MARGIN);

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [ADDR_BITS:0]   count_q, count_n;
    logic [WIDTH-1:0]     top_q, top_n;
    logic [WIDTH-1:0]     dout_q, dout_n;
    logic                 valid_q, valid_n;
    logic                 ovf_q, ovf_n;
    logic                 unf_q, unf_n;
    logic                 full_q, empty_q, af_q, ae_q;
    logic                 wr_en;
    logic [ADDR_BITS-1:0] wr_addr;
    logic [ADDR_BITS-1:0] below_idx;
    logic                 is_empty, is_full;

    assign is_empty  = (count_q == '0);
    assign is_full   = (count_q == DEPTH_C);
    // Entry just below the top; after a Pop it becomes the new top. When
    // Count is 1 this wraps to an unused slot, which is harmless because the
    // stack becomes empty and the top register is then don't-care.
    assign below_idx = ADDR_BITS'(count_q - 2'd2);

    always_comb begin
        count_n = count_q;
        top_n   = top_q;
        dout_n  = dout_q;
        valid_n = valid_q;
        ovf_n   = ovf_q;
        unf_n   = unf_q;
        wr_en   = 1'b0;
        wr_addr = ADDR_BITS'(count_q);
        if (Enable) begin
            valid_n = 1'b0;
            if (ErrClr) begin
                ovf_n = 1'b0;
                unf_n = 1'b0;
            end
            if (Clear) begin
                count_n = '0;
            end else if (Push && Pop) begin
                if (is_empty) begin
                    // Replace on an empty stack degenerates to a plain push.
                    wr_en   = 1'b1;
                    top_n   = DataIn;
                    count_n = count_q + 1'b1;
                end else begin
                    wr_en   = 1'b1;
                    wr_addr = ADDR_BITS'(count_q - 1'b1);
                    dout_n  = top_q;
                    valid_n = 1'b1;
                    top_n   = DataIn;
                end
            end else if (Push) begin
                if (is_full) begin
                    ovf_n = 1'b1;
                end else begin
                    wr_en   = 1'b1;
                    top_n   = DataIn;
                    count_n = count_q + 1'b1;
                end
            end else if (Pop) begin
                if (is_empty) begin
                    unf_n = 1'b1;
                end else begin
                    dout_n  = top_q;
                    valid_n = 1'b1;
                    top_n   = mem[below_idx];
                    count_n = count_q - 1'b1;
                end
            end else if (Top) begin
                if (is_empty) begin
                    unf_n = 1'b1;
                end else begin
                    dout_n  = top_q;
                    valid_n = 1'b1;
                end
            end
        end
    end

    // Storage is not reset; writes are suppressed while reset is asserted.
    always_ff @(posedge Clk) begin
        if (ResetN && wr_en) begin
            mem[wr_addr] <= DataIn;
        end
    end

    always_ff @(posedge Clk) begin
        if (!ResetN) begin
            count_q <= '0;
            top_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
        end else begin
            count_q <= count_n;
            top_q   <= top_n;
            dout_q  <= dout_n;
            valid_q <= valid_n;
            ovf_q   <= ovf_n;
            unf_q   <= unf_n;
            // Flags are derived from the next count so they line up with Count.
            full_q  <= (count_n == DEPTH_C);
            empty_q <= (count_n == '0);
            af_q    <= (count_n >= AF_LVL);
            ae_q    <= (count_n <= AE_LVL);
        end
    end

    assign DataOut     = dout_q;
    assign OutValid    = valid_q;
    assign Count       = count_q;
    assign Full        = full_q;
    assign Empty       = empty_q;
    assign AlmostFull  = af_q;
    assign AlmostEmpty = ae_q;
    assign Overflow    = ovf_q;
    assign Underflow   = unf_q;

endmodule
